// File: rtl/pattern_pkg.sv
// rtl/pattern_pkg.sv - shared constants and FSM state type for the pattern RAM writer
// PARITY_CHECK_EN widens each serial word by one trailing even-parity bit.
package pattern_pkg;
  localparam int WORD_W = 16;
  localparam int DEPTH  = 8;
  localparam int ADR_W  = 3;
`ifdef PARITY_CHECK_EN
  localparam int SER_W  = WORD_W + 1;
`else
  localparam int SER_W  = WORD_W;
`endif
  localparam int CNT_W  = $clog2(SER_W);

  typedef enum logic [1:0] {IDLE, SHIFT, WRITE, DONE} state_e;
endpackage

// File: rtl/word_deser.sv
// rtl/word_deser.sv - MSB-first serial-to-parallel word shifter with bit counter
// PARITY_CHECK_EN: the last serial bit is even parity, checked via par_ok_o.
module word_deser
  import pattern_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              sin_i,
  input  logic              sin_valid_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_rdy_o,
  output logic              par_ok_o
);
  logic [SER_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (sin_valid_i) begin
      shreg_d = {shreg_q[SER_W-2:0], sin_i};
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Asserted on the cycle the final serial bit is being taken.
  assign word_rdy_o = sin_valid_i && (cnt_q == CNT_W'(SER_W - 1));

`ifdef PARITY_CHECK_EN
  assign word_o   = shreg_q[SER_W-1:1];
  assign par_ok_o = ~(^shreg_q);
`else
  assign word_o   = shreg_q;
  assign par_ok_o = 1'b1;
`endif
endmodule

// File: rtl/pattern_ram_writer.sv
// rtl/pattern_ram_writer.sv - loads DEPTH serial words into the pattern store, async read port
// PARITY_CHECK_EN: words failing parity are dropped and flagged on perr_o for retransmission.
module pattern_ram_writer
  import pattern_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              sin_i,
  input  logic              sin_valid_i,
  input  logic [ADR_W-1:0]  adr_i,
  output logic [WORD_W-1:0] data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              perr_o
);
  state_e              state_q;
  logic [ADR_W-1:0]    waddr_q, waddr_d;
  logic [WORD_W-1:0]   mem_q [DEPTH];
  logic                busy_q, done_q, perr_q;
  logic                take_start, deser_clr, deser_valid, word_rdy, par_ok;
  logic [WORD_W-1:0]   word;

  assign take_start  = start_i && ((state_q == IDLE) || (state_q == DONE));
  assign deser_clr   = take_start || (state_q == WRITE);
  assign deser_valid = sin_valid_i && (state_q == SHIFT);
  assign waddr_d     = waddr_q + ADR_W'(1);

  word_deser u_deser (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clr_i       (deser_clr),
    .sin_i       (sin_i),
    .sin_valid_i (deser_valid),
    .word_o      (word),
    .word_rdy_o  (word_rdy),
    .par_ok_o    (par_ok)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      waddr_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
      mem_q   <= '{default: '0};
    end else begin
      perr_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_q <= SHIFT;
            waddr_q <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        SHIFT: begin
          if (word_rdy) state_q <= WRITE;
        end
        WRITE: begin
          if (!par_ok) begin
            perr_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            mem_q[waddr_q] <= word;
            if (waddr_q == ADR_W'(DEPTH - 1)) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              waddr_q <= waddr_d;
              state_q <= SHIFT;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // No write-through: a read of the entry being written shows the old word.
  assign data_o = mem_q[adr_i];
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign perr_o = perr_q;
endmodule

// File: tb/tb_pattern_ram_writer.sv
// tb/tb_pattern_ram_writer.sv - directed/randomized bench for pattern_ram_writer (PARITY_CHECK_EN aware)
module tb_pattern_ram_writer;
`ifdef PARITY_CHECK_EN
  localparam int BITS = 17;
`else
  localparam int BITS = 16;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, sin_i, sin_valid_i;
  logic [2:0]  adr_i;
  logic [15:0] data_o;
  logic        busy_o, done_o, perr_o;

  int          checks = 0, errors = 0;
  int          cyc = 0, done_rise_cyc = 0, perr_total = 0;
  logic        done_prev = 1'b0;
  logic [15:0] ref_mem [8];
  logic [15:0] cur [8];
  bit          start_noise = 1'b0;

  pattern_ram_writer dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .sin_i       (sin_i),
    .sin_valid_i (sin_valid_i),
    .adr_i       (adr_i),
    .data_o      (data_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .perr_o      (perr_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    done_prev <= done_o;
    if (done_o && !done_prev) done_rise_cyc <= cyc;
    if (perr_o) perr_total <= perr_total + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 8; i++) begin
      adr_i = 3'(i);
      #1;
      check($sformatf("%s[%0d]", tag, i), {16'h0, data_o}, {16'h0, ref_mem[i]});
    end
  endtask

  // Called at a negedge with the DUT in SHIFT; returns at the negedge after the WRITE edge.
  task automatic send_word(input logic [15:0] w, input int stall, input bit bad, input int coll_idx);
    for (int b = 15; b >= 0; b--) begin
      if (stall > 0 && b == 7) begin
        repeat (stall) begin
          sin_valid_i = 1'b0;
          sin_i       = 1'($urandom);
          @(negedge clk_i);
        end
      end
      sin_i       = w[b];
      sin_valid_i = 1'b1;
      start_i     = start_noise ? 1'($urandom) : 1'b0;
      @(negedge clk_i);
    end
`ifdef PARITY_CHECK_EN
    sin_i       = bad ? ~(^w) : ^w;
    sin_valid_i = 1'b1;
    @(negedge clk_i);
`endif
    start_i     = 1'b0;
    sin_i       = 1'($urandom) ^ bad;
    sin_valid_i = 1'b1;
    if (coll_idx >= 0) begin
      adr_i = coll_idx[2:0];
      #1;
      check("coll_old", {16'h0, data_o}, {16'h0, ref_mem[coll_idx]});
    end
    @(negedge clk_i);
    sin_valid_i = 1'b0;
    if (coll_idx >= 0) begin
      #1;
      check("coll_new", {16'h0, data_o}, {16'h0, w});
    end
  endtask

  task automatic load(input int stall_word, input int stall_len, input int coll_word, input int bad_word);
    int s, base, exp_lat;
    base = perr_total;
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    s = cyc;
    check("busy_start", {31'h0, busy_o}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (i == bad_word) begin
        send_word(cur[i], 0, 1'b1, -1);
        #1;
        check("perr_once", perr_total - base, 32'd1);
        adr_i = 3'(i);
        #1;
        check("bad_keep", {16'h0, data_o}, {16'h0, ref_mem[i]});
      end
      send_word(cur[i], (i == stall_word) ? stall_len : 0, 1'b0, (i == coll_word) ? i : -1);
      ref_mem[i] = cur[i];
    end
    #1;
    exp_lat = 8 * (BITS + 1) + ((stall_word >= 0) ? stall_len : 0) + ((bad_word >= 0) ? BITS + 1 : 0);
    check("done_lat", done_rise_cyc - s, exp_lat);
    check("done_end", {31'h0, done_o}, 32'd1);
    check("busy_end", {31'h0, busy_o}, 32'd0);
    check("perr_total", perr_total - base, (bad_word >= 0) ? 32'd1 : 32'd0);
    check_mem("mem");
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; sin_i = 1'b0; sin_valid_i = 1'b0; adr_i = '0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 8; i++) ref_mem[i] = 16'h0000;
    check("rst_busy", {31'h0, busy_o}, 32'd0);
    check("rst_done", {31'h0, done_o}, 32'd0);
    check("rst_perr", {31'h0, perr_o}, 32'd0);
    check_mem("rst");

    cur = '{16'hFFFF, 16'h5555, 16'h6666, 16'h679E, 16'h67BD, 16'h0000, 16'h67C1, 16'h67C1};
    load(-1, 0, -1, -1);
    adr_i = 3'd1; #1; check("adr1", {16'h0, data_o}, 32'h5555);
    adr_i = 3'd3; #1; check("adr3", {16'h0, data_o}, 32'h679E);

    for (int i = 0; i < 8; i++) cur[i] = 16'($urandom);
    start_noise = 1'b1;
    load(-1, 0, -1, -1);
    start_noise = 1'b0;

    cur = '{16'hFFFF, 16'h5555, 16'h6666, 16'h679E, 16'h67BD, 16'h0000, 16'h67C1, 16'h67C1};
    load(2, 5, 4, -1);

    for (int i = 0; i < 8; i++) cur[i] = 16'($urandom);
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_word(cur[i], 0, 1'b0, -1);
      ref_mem[i] = cur[i];
    end
    check_mem("partial");
    for (int b = 0; b < 5; b++) begin
      sin_i = 1'($urandom); sin_valid_i = 1'b1;
      @(negedge clk_i);
    end
    sin_valid_i = 1'b0;
    rst_i = 1'b1;
    #1;
    check("midrst_busy", {31'h0, busy_o}, 32'd0);
    check("midrst_done", {31'h0, done_o}, 32'd0);
    for (int i = 0; i < 8; i++) ref_mem[i] = 16'h0000;
    check_mem("midrst");
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 8; i++) cur[i] = 16'($urandom);
    load(-1, 0, -1, -1);

`ifdef PARITY_CHECK_EN
    cur = '{16'hFFFF, 16'h5555, 16'h6666, 16'h679E, 16'h67BD, 16'h0000, 16'h67C1, 16'h67C1};
    for (int i = 0; i < 8; i++) ref_mem[i] = ref_mem[i];
    load(-1, 0, -1, 2);
    adr_i = 3'd2; #1; check("par_adr2", {16'h0, data_o}, 32'h6666);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
